// File: rtl/counter_pkg.sv
// counter_pkg: shared mode/direction encodings for mode_counter.
package counter_pkg;

  typedef enum logic {
    COUNT_WRAP     = 1'b0,
    COUNT_SATURATE = 1'b1
  } counter_mode_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits one tick every ratio+1 enabled cycles.
// The phase only moves while enable is high; restart or reset return it to 0.
module counter_prescaler #(
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      restart,
  input  logic [PRESCALE_WIDTH-1:0] ratio,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] phase_q;
  logic [PRESCALE_WIDTH-1:0] phase_d;

  // Tick on the enabled cycle whose phase matches the ratio; phase then restarts.
  always_comb begin
    tick    = enable && (phase_q == ratio);
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = tick ? '0 : phase_q + 1'b1;
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// mode_counter: parametrised up/down counter with runtime limit, wrap or
// saturate mode, synchronous clear/load and a registered wrap pulse.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      io_clear,
  input  logic                      io_load,
  input  logic [WIDTH-1:0]          io_load_value,
  input  logic                      io_enable,
  input  logic                      io_up,
  input  logic                      io_mode,
  input  logic [WIDTH-1:0]          io_limit,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] io_prescale,
`endif
  output logic [WIDTH-1:0]          io_value,
  output logic                      io_full,
  output logic                      io_empty,
  output logic                      io_wrap
);

  // Elaboration-time parameter sanity.
  if (WIDTH < 2) begin : g_bad_width
    $error("mode_counter: WIDTH must be at least 2");
  end
  if (PRESCALE_WIDTH < 1) begin : g_bad_pw
    $error("mode_counter: PRESCALE_WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             step;
  counter_mode_t    mode;

  assign mode = counter_mode_t'(io_mode);

`ifdef COUNTER_PRESCALE_EN
  // Clear and load both restart the prescaler so the next step interval is full.
  counter_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (io_enable),
    .restart (io_clear | io_load),
    .ratio   (io_prescale),
    .tick    (step)
  );
`else
  assign step = io_enable;
`endif

  // Next count: clear > load > step > hold. Limit compare precedes the
  // increment, so the count never relies on modulo-2^WIDTH rollover.
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (io_clear) begin
      value_d = '0;
    end else if (io_load) begin
      value_d = io_load_value;
    end else if (step) begin
      if (io_up == DIR_UP) begin
        if (value_q >= io_limit) begin
          if (mode == COUNT_WRAP) begin
            value_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          value_d = value_q + 1'b1;
        end
      end else begin
        if (value_q == '0) begin
          if (mode == COUNT_WRAP) begin
            value_d = io_limit;
            wrap_d  = 1'b1;
          end
        end else begin
          value_d = value_q - 1'b1;
        end
      end
    end
  end

  // Count and wrap-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign io_value = value_q;
  assign io_wrap  = wrap_q;
  assign io_full  = (value_q >= io_limit);
  assign io_empty = (value_q == '0);

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter (WIDTH=4). Define COUNTER_PRESCALE_EN
// to exercise the prescaler build as well.
module tb_mode_counter;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          io_clear = 1'b0;
  logic          io_load = 1'b0;
  logic [W-1:0]  io_load_value = '0;
  logic          io_enable = 1'b0;
  logic          io_up = 1'b1;
  logic          io_mode = 1'b0;
  logic [W-1:0]  io_limit = 4'd15;
  logic [PW-1:0] io_prescale = '0;
  logic [W-1:0]  io_value;
  logic          io_full;
  logic          io_empty;
  logic          io_wrap;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // reference state
  int m_val = 0;
  int m_wrap = 0;
  int m_phase = 0;

  mode_counter #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_clear      (io_clear),
    .io_load       (io_load),
    .io_load_value (io_load_value),
    .io_enable     (io_enable),
    .io_up         (io_up),
    .io_mode       (io_mode),
    .io_limit      (io_limit),
`ifdef COUNTER_PRESCALE_EN
    .io_prescale   (io_prescale),
`endif
    .io_value      (io_value),
    .io_full       (io_full),
    .io_empty      (io_empty),
    .io_wrap       (io_wrap)
  );

  always #5 clk = ~clk;

  // Reference model: evaluates the counting rules with plain integers.
  always @(posedge clk) begin
    int lim;
    bit stp;
    lim = int'(io_limit);
    if (reset) begin
      m_val = 0; m_wrap = 0; m_phase = 0;
    end else begin
      m_wrap = 0;
`ifdef COUNTER_PRESCALE_EN
      stp = io_enable && (m_phase == int'(io_prescale));
      if (io_clear || io_load) m_phase = 0;
      else if (io_enable) m_phase = stp ? 0 : (m_phase + 1) % (1 << PW);
`else
      stp = io_enable;
`endif
      if (io_clear) m_val = 0;
      else if (io_load) m_val = int'(io_load_value);
      else if (stp) begin
        if (io_up) begin
          if (m_val >= lim) begin
            if (!io_mode) begin m_val = 0; m_wrap = 1; end
          end else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin
            if (!io_mode) begin m_val = lim; m_wrap = 1; end
          end else m_val = m_val - 1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      int ef, ee;
      ef = (m_val >= int'(io_limit)) ? 1 : 0;
      ee = (m_val == 0) ? 1 : 0;
      vectors++;
      if (int'(io_value) != m_val || int'(io_wrap) != m_wrap ||
          int'(io_full) != ef || int'(io_empty) != ee) begin
        miscompares++;
        $display("FAIL model t=%0t value=%0d/%0d wrap=%0d/%0d full=%0d/%0d empty=%0d/%0d (got/expected)",
                 $time, io_value, m_val, io_wrap, m_wrap, io_full, ef, io_empty, ee);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 2 time units after the edge.
  task automatic apply(input bit rst, input bit clr, input bit ld, input int lv,
                       input bit en, input bit up, input bit md, input int lim);
    reset = rst; io_clear = clr; io_load = ld; io_load_value = W'(lv);
    io_enable = en; io_up = up; io_mode = md; io_limit = W'(lim);
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset
    apply(1, 0, 0, 0, 0, 1, 0, 15);
    chk_on = 1'b1;
    lit("rst_value", io_value, 0);
    lit("rst_wrap", io_wrap, 0);
    lit("rst_empty", io_empty, 1);
    lit("rst_full_lim15", io_full, 0);
    io_limit = 4'd0; #1;
    lit("rst_full_lim0", io_full, 1);

    // full-range wrap count, limit 15
    for (int i = 1; i <= 17; i++) begin
      apply(0, 0, 0, 0, 1, 1, 0, 15);
      if (i == 15) begin lit("t1_val15", io_value, 15); lit("t1_full15", io_full, 1); end
      if (i == 16) begin lit("t1_wrapval", io_value, 0); lit("t1_wrappulse", io_wrap, 1); end
      if (i == 17) begin lit("t1_val1", io_value, 1); lit("t1_wrapgone", io_wrap, 0); end
    end

    // saturate at 5
    apply(0, 1, 0, 0, 0, 1, 1, 5);
    for (int i = 0; i < 10; i++) apply(0, 0, 0, 0, 1, 1, 1, 5);
    lit("t2_sat", io_value, 5);
    lit("t2_full", io_full, 1);
    lit("t2_nowrap", io_wrap, 0);

    // load 3, count down with limit 9
    apply(0, 0, 1, 3, 0, 0, 0, 9);
    for (int i = 1; i <= 5; i++) begin
      apply(0, 0, 0, 0, 1, 0, 0, 9);
      if (i == 3) lit("t3_empty", io_empty, 1);
      if (i == 4) begin lit("t3_val9", io_value, 9); lit("t3_wrap", io_wrap, 1); end
      if (i == 5) lit("t3_val8", io_value, 8);
    end

    // clear+load+enable at value 4
    apply(0, 0, 1, 4, 0, 1, 0, 15);
    apply(0, 1, 1, 7, 1, 1, 0, 15);
    lit("t4_clr", io_value, 0);
    lit("t4_clrwrap", io_wrap, 0);
    apply(0, 0, 1, 7, 0, 1, 0, 15);
    lit("t4_load", io_value, 7);

    // load above limit, then reset mid-count
    apply(0, 0, 1, 12, 0, 1, 0, 8);
    apply(0, 0, 0, 0, 1, 1, 0, 8);
    lit("t5_wrap0", io_value, 0);
    lit("t5_wrappulse", io_wrap, 1);
    for (int i = 0; i < 6; i++) apply(0, 0, 0, 0, 1, 1, 0, 8);
    lit("t5_val6", io_value, 6);
    apply(1, 0, 1, 5, 1, 1, 0, 8);
    lit("t5_rst", io_value, 0);
    lit("t5_rstwrap", io_wrap, 0);

`ifdef COUNTER_PRESCALE_EN
    io_prescale = 4'd2;
    apply(0, 1, 0, 0, 0, 1, 0, 15);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 1, 1, 0, 15);
    lit("p_first", io_value, 1);
    apply(0, 0, 0, 0, 1, 1, 0, 15);
    apply(0, 0, 0, 0, 0, 1, 0, 15);
    apply(0, 0, 0, 0, 0, 1, 0, 15);
    apply(0, 0, 0, 0, 1, 1, 0, 15);
    lit("p_stretch_hold", io_value, 1);
    apply(0, 0, 0, 0, 1, 1, 0, 15);
    lit("p_stretch_step", io_value, 2);
`endif

    // randomized traffic against the model
    begin
      int lim = 15;
      for (int i = 0; i < 2000; i++) begin
        bit rst, clr, ld, en, up, md;
        int lv;
        rst = ($urandom % 60) == 0;
        clr = ($urandom % 25) == 0;
        ld  = ($urandom % 12) == 0;
        lv  = int'($urandom % 16);
        en  = ($urandom % 4) != 0;
        up  = ($urandom % 3) != 0;
        md  = ($urandom % 3) == 0;
        if (($urandom % 20) == 0) begin
          case ($urandom % 4)
            0: lim = 0;
            1: lim = 15;
            default: lim = int'($urandom % 16);
          endcase
        end
        if (($urandom % 50) == 0) io_prescale = PW'($urandom % 4);
        apply(rst, clr, ld, lv, en, up, md, lim);
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
